// File: rtl/rot_pkg.sv
// Shared constants and command type for the 8-bit rotator path.
// Also used by the shifter's wrapper.
package rot_pkg;

    localparam int ROT_W = 8;
    localparam int AMT_W = 3;

    // One queued rotate command. The field order gives a 12-bit entry laid out as {data, lr, amt}.
    typedef struct packed {
        logic [ROT_W-1:0] data;
        logic             lr;
        logic [AMT_W-1:0] amt;
    } rot_cmd_t;

endpackage

// File: rtl/rot_cmd_fifo.sv
// Command FIFO for the rotate feeder.
// DEPTH must be a power of two and at least 2.
// The pointers carry one extra bit beyond the index bits. Only the low bits address storage.
module rot_cmd_fifo
    import rot_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  rot_cmd_t      i_wdata,
    input  logic          i_pop,
    output rot_cmd_t      o_head,
    output logic [CW-1:0] o_count
);

    rot_cmd_t      r_mem [DEPTH];
    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage write. It has no reset because the head is masked by the parent while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
        end
    end

    // Pointer advance and occupancy tracking. A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + CW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + CW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr[PW-1:0]];
    assign o_count = r_count;

endmodule

// File: rtl/rotate_cmd_feeder.sv
// Front end for the combinational 8-bit barrel shifter.
// It queues rotate commands and presents the FIFO head to the shifter.
// It captures the shifter result into a backpressured output register.
// Optional feature: define ROT_FEED_CNT_EN to add the 16-bit op_count port,
// which counts completed results.
module rotate_cmd_feeder
    import rot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROT_W-1:0] in_data,
    input  logic             in_lr,
    input  logic [AMT_W-1:0] in_amt,
    output logic [ROT_W-1:0] sh_data,
    output logic             sh_lr,
    output logic [AMT_W-1:0] sh_ctrl,
    input  logic [ROT_W-1:0] sh_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ROT_W-1:0] res_data
`ifdef ROT_FEED_CNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    w_count;
    rot_cmd_t         w_head;
    rot_cmd_t         w_wdata;
    logic             w_nonempty;
    logic             w_push;
    logic             w_pop;
    logic             r_res_valid;
    logic [ROT_W-1:0] r_res_data;

    assign w_nonempty = (w_count != '0);
    // in_ready depends only on occupancy, so there is no bypass when the FIFO is full.
    assign in_ready   = (w_count != CW'(DEPTH));
    assign w_push     = in_valid && in_ready;
    assign w_pop      = w_nonempty && (!r_res_valid || res_ready);
    assign w_wdata    = '{data: in_data, lr: in_lr, amt: in_amt};

    rot_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign sh_data = w_nonempty ? w_head.data : '0;
    assign sh_lr   = w_nonempty ? w_head.lr   : 1'b0;
    assign sh_ctrl = w_nonempty ? w_head.amt  : '0;

    // Output register: capture the shifter result on a pop.
    // Otherwise drop valid once the consumer takes it. Data holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (w_pop) begin
            r_res_valid <= 1'b1;
            r_res_data  <= sh_out;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

`ifdef ROT_FEED_CNT_EN
    logic [15:0] r_op_count;

    // Count of captured results. It wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_pop) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_rotate_cmd_feeder.sv
// Self-checking bench for rotate_cmd_feeder with a behavioural shifter model.
module tb_rotate_cmd_feeder;
    import rot_pkg::*;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_lr     = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic [2:0] in_amt    = 3'd0;
    logic       res_ready = 1'b0;
    logic       in_ready;
    logic [7:0] sh_data;
    logic       sh_lr;
    logic [2:0] sh_ctrl;
    logic [7:0] sh_out;
    logic       res_valid;
    logic [7:0] res_data;
`ifdef ROT_FEED_CNT_EN
    logic [15:0] op_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    rotate_cmd_feeder #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_lr     (in_lr),
        .in_amt    (in_amt),
        .sh_data   (sh_data),
        .sh_lr     (sh_lr),
        .sh_ctrl   (sh_ctrl),
        .sh_out    (sh_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
`ifdef ROT_FEED_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    // External combinational shifter
    always_comb begin
        if (sh_lr) sh_out = (sh_data << sh_ctrl) | (sh_data >> (4'd8 - {1'b0, sh_ctrl}));
        else       sh_out = (sh_data >> sh_ctrl) | (sh_data << (4'd8 - {1'b0, sh_ctrl}));
    end

    // Reference rotate: one bit position per step
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic lr, input logic [2:0] a);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < int'(a); i++) r = lr ? {r[6:0], r[7]} : {r[0], r[7:1]};
        return r;
    endfunction

    // One clock: sample handshakes at negedge, record accepted commands, return at posedge+1
    task automatic cycle(output logic acc, output logic fire, output logic [7:0] got);
        @(negedge clk);
        acc  = in_valid && in_ready;
        fire = res_valid && res_ready;
        got  = res_data;
        if (acc) exp_q.push_back(ref_rot(in_data, in_lr, in_amt));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data got=%h want=00", res_data); end
        checks++; if ({sh_data, sh_lr, sh_ctrl} !== 12'h000) begin errors++; $display("FAIL reset_sh got=%h want=000", {sh_data, sh_lr, sh_ctrl}); end
`ifdef ROT_FEED_CNT_EN
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Single command into an idle feeder: checks latency, head drive and the result
    task automatic run_single(input logic [7:0] d, input logic lr, input logic [2:0] a,
                              input logic [7:0] want, input string nm);
        logic acc, fire;
        logic [7:0] got, e;
        res_ready = 1'b1;
        in_valid = 1'b1; in_data = d; in_lr = lr; in_amt = a;
        cycle(acc, fire, got);
        in_valid = 1'b0;
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL %s_accept got=%b want=1", nm, acc); end
        checks++; if ({sh_data, sh_lr, sh_ctrl} !== {d, lr, a}) begin errors++; $display("FAIL %s_head got=%h want=%h", nm, {sh_data, sh_lr, sh_ctrl}, {d, lr, a}); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got=%b want=0", nm, res_valid); end
        cycle(acc, fire, got);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL %s_latency got=%b want=1", nm, res_valid); end
        checks++; if (res_data !== want) begin errors++; $display("FAIL %s_data got=%h want=%h", nm, res_data, want); end
        checks++; if (sh_data !== 8'h00) begin errors++; $display("FAIL %s_sh_empty got=%h want=00", nm, sh_data); end
        cycle(acc, fire, got);
        checks++;
        if (fire !== 1'b1) begin errors++; $display("FAIL %s_fire got=%b want=1", nm, fire); end
        else if (exp_q.size() == 0) begin errors++; $display("FAIL %s_sb got=%h want=<none>", nm, got); end
        else begin
            e = exp_q.pop_front();
            if (got !== e) begin errors++; $display("FAIL %s_sb got=%h want=%h", nm, got, e); end
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL %s_drop got=%b want=0", nm, res_valid); end
    endtask

    task automatic test_directed;
        run_single(8'hCC, 1'b1, 3'd1, 8'h99, "rotl1");
        run_single(8'hF0, 1'b0, 3'd4, 8'h0F, "rotr4");
        run_single(8'h81, 1'b0, 3'd1, 8'hC0, "rotr1");
        run_single(8'h5A, 1'b1, 3'd0, 8'h5A, "amt0");
    endtask

    task automatic test_capacity;
        logic acc, fire;
        logic [7:0] got, e, held;
        int accepts = 0, fires = 0, first = -1, last = -1;
        held = 8'h00;
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h13 * (accepts + 1));
            in_lr    = accepts[0];
            in_amt   = 3'(accepts + 2);
            cycle(acc, fire, got);
            if (acc) accepts++;
            if (i == 1) held = res_data;
            if (i >= 2) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== held) begin
                    errors++; $display("FAIL hold_stable got=%b/%h want=1/%h", res_valid, res_data, held);
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (accepts != 5) begin errors++; $display("FAIL capacity_accepts got=%0d want=5", accepts); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL capacity_in_ready got=%b want=0", in_ready); end
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(acc, fire, got);
            if (fire) begin
                if (first < 0) begin
                    first = i;
                    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got=%b want=1", in_ready); end
                end
                last = i;
                fires++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL drain_sb got=%h want=<none>", got);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (got !== e) begin errors++; $display("FAIL drain_sb got=%h want=%h", got, e); end
                end
            end
        end
        checks++; if (fires != 5) begin errors++; $display("FAIL drain_count got=%0d want=5", fires); end
        checks++; if (last - first != 4) begin errors++; $display("FAIL drain_bubbles got=%0d want=4", last - first); end
    endtask

    task automatic test_back_to_back;
        logic acc, fire;
        logic [7:0] got, e;
        int fires = 0, first = -1, last = -1;
        res_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                in_lr    = 1'($urandom);
                in_amt   = 3'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            cycle(acc, fire, got);
            if (i < 8) begin
                checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle=%0d got=%b want=1", i, acc); end
            end
            if (fire) begin
                if (first < 0) first = i;
                last = i;
                fires++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_sb got=%h want=<none>", got);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (got !== e) begin errors++; $display("FAIL b2b_sb got=%h want=%h", got, e); end
                end
            end
        end
        checks++; if (fires != 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", fires); end
        checks++; if (last - first != 7) begin errors++; $display("FAIL b2b_bubbles got=%0d want=7", last - first); end
    endtask

    task automatic test_reset_mid;
        logic acc, fire;
        logic [7:0] got;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h21 + i);
            in_lr    = 1'b1;
            in_amt   = 3'(i);
            cycle(acc, fire, got);
        end
        in_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL pre_reset got=%b%b want=11", res_valid, in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_res_valid got=%b want=0", res_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        checks++; if (sh_data !== 8'h00 || res_data !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h/%h want=00/00", sh_data, res_data); end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_single(8'h01, 1'b1, 3'd7, 8'h80, "post_rst");
    endtask

`ifdef ROT_FEED_CNT_EN
    task automatic test_op_count;
        logic acc, fire;
        logic [7:0] got;
        rst_n = 1'b0;
        #3;
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%0d want=0", op_count); end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 26; i++) begin
            in_valid = (i < 20);
            in_data  = 8'(i);
            in_lr    = 1'b0;
            in_amt   = 3'(i);
            cycle(acc, fire, got);
        end
        in_valid = 1'b0;
        exp_q.delete();
        checks++; if (op_count !== 16'd20) begin errors++; $display("FAIL cnt_20 got=%0d want=20", op_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_capacity();
        test_back_to_back();
        test_reset_mid();
`ifdef ROT_FEED_CNT_EN
        test_op_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
